// File: rtl/sfc_pkg.sv
// Shared types and constants for the space-filling-curve address generator.
package sfc_pkg;

   localparam int unsigned SfcDataWidth = 15;
   localparam int unsigned SfcAddrWidth = 31;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } sfc_state_e;

   // elem_shift encodings: log2 of the element size in bytes
   localparam logic [1:0] ElemShift1B = 2'd0;
   localparam logic [1:0] ElemShift2B = 2'd1;
   localparam logic [1:0] ElemShift4B = 2'd2;
   localparam logic [1:0] ElemShift8B = 2'd3;

endpackage

// File: rtl/sfc_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready and out_valid come straight from the entry count.
module sfc_skid_buf #(
   parameter int unsigned Width = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Width-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Width-1:0] out_data
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       cnt_q;
   logic             push;
   logic             pop;

   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/sfc_addr_gen.sv
// Converts (x, y) coordinates to byte addresses through a 2-stage pipeline and a skid buffer.
// Optional bounds checking (drop + sticky err) is enabled by SFC_ADDR_BOUNDS_CHECK_EN.
module sfc_addr_gen
   import sfc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SfcDataWidth,
   parameter int unsigned ADDR_WIDTH = SfcAddrWidth
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [DATA_WIDTH:0] W,
   input  logic [DATA_WIDTH:0] H,
   input  logic [ADDR_WIDTH:0] base_addr,
   input  logic [DATA_WIDTH:0] row_stride,
   input  logic [1:0]          elem_shift,
   input  logic [DATA_WIDTH:0] in_x,
   input  logic [DATA_WIDTH:0] in_y,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [ADDR_WIDTH:0] out_addr,
   output logic                out_valid,
   output logic                out_last,
   input  logic                out_ready,
   output logic [ADDR_WIDTH:0] addr_count,
   output logic                busy,
   output logic                done
`ifdef SFC_ADDR_BOUNDS_CHECK_EN
   ,
   output logic                err
`endif
);

   localparam int unsigned DW = DATA_WIDTH + 1;
   localparam int unsigned AW = ADDR_WIDTH + 1;
   localparam int unsigned PW = 2 * DW;

   sfc_state_e    state_q, state_d;
   logic          s1_valid_q, s1_last_q, s1_mark_q;
   logic [AW-1:0] s1_lin_q;
   logic          s2_valid_q, s2_last_q, s2_mark_q;
   logic [AW-1:0] s2_addr_q;
   logic [AW-1:0] addr_count_q;
   logic          s1_ready, s2_ready, skid_in_ready;
   logic          in_hs, out_hs, in_drop, out_mark, pass_start;
   logic [PW-1:0] prod;
   logic [AW-1:0] lin_d;
   logic [AW+1:0] skid_out_data;

`ifdef SFC_ADDR_BOUNDS_CHECK_EN
   logic err_q;
   assign in_drop = (in_x > W) || (in_y > H);
   assign err     = err_q;
`else
   logic unused_dims;
   assign in_drop     = 1'b0;
   assign unused_dims = ^{W, H};
`endif

   assign prod  = PW'(in_y) * PW'(row_stride);
   assign lin_d = AW'(prod) + AW'(in_x);

   // Readiness is derived from registered occupancy only, so in_ready never sees out_ready.
   assign s2_ready   = !s2_valid_q || skid_in_ready;
   assign s1_ready   = !s1_valid_q || s2_ready;
   assign in_hs      = in_valid && in_ready;
   assign out_hs     = out_valid && out_ready;
   assign pass_start = (state_q == StIdle) && enable;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StRun;
         end
         StRun: begin
            in_ready = s1_ready;
            busy     = 1'b1;
            if (in_valid && s1_ready && in_last) state_d = StDrain;
         end
         StDrain: begin
            busy = 1'b1;
            if (out_hs && out_last) state_d = StDone;
         end
         StDone: begin
            done = 1'b1;
            if (!enable) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_mark_q  <= 1'b0;
         s1_lin_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_mark_q  <= 1'b0;
         s2_addr_q  <= '0;
      end else begin
         if (s1_ready) begin
            // A dropped coordinate survives only as a zero-length marker carrying last.
            s1_valid_q <= in_hs && (!in_drop || in_last);
            s1_last_q  <= in_last;
            s1_mark_q  <= in_drop;
            s1_lin_q   <= lin_d;
         end
         if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_mark_q  <= s1_mark_q;
            s2_addr_q  <= base_addr + (s1_lin_q << elem_shift);
         end
      end
   end

   sfc_skid_buf #(
      .Width(AW + 2)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s2_valid_q),
      .in_ready (skid_in_ready),
      .in_data  ({s2_mark_q, s2_last_q, s2_addr_q}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (skid_out_data)
   );

   assign out_mark   = skid_out_data[AW+1];
   assign out_last   = skid_out_data[AW];
   assign out_addr   = skid_out_data[AW-1:0];
   assign addr_count = addr_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         addr_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (pass_start) begin
            addr_count_q <= '0;
         end else if (out_hs && !out_mark) begin
            addr_count_q <= addr_count_q + AW'(1);
         end
      end
   end

`ifdef SFC_ADDR_BOUNDS_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (pass_start) begin
         err_q <= 1'b0;
      end else if (in_hs && in_drop) begin
         err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sfc_addr_gen.sv
// Scoreboard bench for sfc_addr_gen: expected {last, addr} queued on input handshake,
// popped and compared on output handshake.
module tb_sfc_addr_gen;

   localparam int DW = 16;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [DW-1:0] W, H, row_stride, in_x, in_y;
   logic [AW-1:0] base_addr;
   logic [1:0]    elem_shift;
   logic          in_valid, in_last, in_ready;
   logic [AW-1:0] out_addr, addr_count;
   logic          out_valid, out_last, out_ready, busy, done;
`ifdef SFC_ADDR_BOUNDS_CHECK_EN
   logic          err;
`endif

   int            total = 0;
   int            bad = 0;
   logic [AW:0]   exp_q [$];

   always #5 clk = ~clk;

   sfc_addr_gen dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .W         (W),
      .H         (H),
      .base_addr (base_addr),
      .row_stride(row_stride),
      .elem_shift(elem_shift),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .addr_count(addr_count),
      .busy      (busy),
      .done      (done)
`ifdef SFC_ADDR_BOUNDS_CHECK_EN
      ,
      .err       (err)
`endif
   );

   function automatic logic [AW-1:0] model_addr(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [63:0] lin;
      lin = 64'(y) * 64'(row_stride) + 64'(x);
      lin = lin << elem_shift;
      return base_addr + lin[AW-1:0];
   endfunction

   // Drive one cycle's inputs at negedge, report which handshakes the next posedge performs.
   task automatic step_cycle(input logic iv, input logic [DW-1:0] x, input logic [DW-1:0] y,
                             input logic il, input logic ordy,
                             output logic ihs, output logic ohs, output logic [AW:0] obs);
      @(negedge clk);
      in_valid  = iv;
      in_x      = x;
      in_y      = y;
      in_last   = il;
      out_ready = ordy;
      #1;
      ihs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      obs = {out_last, out_addr};
      @(posedge clk);
   endtask

   task automatic start_pass();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      enable    = 1'b1;
      @(posedge clk);
   endtask

   task automatic end_pass();
      @(negedge clk);
      enable   = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      total++;
      if ({in_ready, out_valid, out_last, busy, done} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b required 00000",
                  {in_ready, out_valid, out_last, busy, done});
      end
      total++;
      if (out_addr !== '0) begin
         bad++;
         $display("FAIL reset_out_addr: got %h required 0", out_addr);
      end
      total++;
      if (addr_count !== '0) begin
         bad++;
         $display("FAIL reset_addr_count: got %0d required 0", addr_count);
      end
`ifdef SFC_ADDR_BOUNDS_CHECK_EN
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL reset_err: got %b required 0", err);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_idle_hold();
      logic ihs, ohs, seen;
      logic [AW:0] obs, e;
      int cyc;
      W = 15; H = 15; base_addr = 32'h3000; row_stride = 2; elem_shift = 2'd3;
      for (int i = 0; i < 4; i++) begin
         step_cycle(1'b1, 16'd5, 16'd7, 1'b1, 1'b1, ihs, ohs, obs);
         total++;
         if (ihs !== 1'b0) begin
            bad++;
            $display("FAIL idle_in_ready: got %b required 0", ihs);
         end
         total++;
         if (ohs !== 1'b0) begin
            bad++;
            $display("FAIL idle_out_valid: got %b required 0", ohs);
         end
      end
      enable = 1'b1;
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 20) begin
         step_cycle(exp_q.size() == 0 && !seen, 16'd5, 16'd7, 1'b1, 1'b1, ihs, ohs, obs);
         if (ihs) exp_q.push_back({1'b1, model_addr(16'd5, 16'd7)});
         if (ohs) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL idle_extra: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e || obs !== {1'b1, 32'h3098}) begin
                  bad++;
                  $display("FAIL idle_addr: got %h required %h", obs, {1'b1, 32'h3098});
               end
            end
            seen = 1'b1;
         end
         cyc++;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL idle_timeout: got no output required one address");
      end
      end_pass();
      exp_q.delete();
   endtask

   task automatic test_raster();
      int idx = 0, nout = 0, cyc = 0, first_in = -1, first_out = -1, last_out = -1;
      logic ihs, ohs, seen;
      logic [AW:0] obs, e, first_obs, last_obs;
      logic [DW-1:0] cx, cy;
      W = 3; H = 1; base_addr = 32'h1000; row_stride = 4; elem_shift = 2'd2;
      start_pass();
      seen = 1'b0;
      while (!seen && cyc < 60) begin
         cx = DW'(idx % 4);
         cy = DW'(idx / 4);
         step_cycle(idx < 8, cx, cy, idx == 7, 1'b1, ihs, ohs, obs);
         if (ihs) begin
            exp_q.push_back({idx == 7, model_addr(cx, cy)});
            if (first_in < 0) first_in = cyc;
            idx++;
         end
         if (ohs) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL raster_extra: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  bad++;
                  $display("FAIL raster_addr: got %h required %h", obs, e);
               end
            end
            if (first_out < 0) begin
               first_out = cyc;
               first_obs = obs;
            end
            last_out = cyc;
            last_obs = obs;
            nout++;
            if (obs[AW]) seen = 1'b1;
         end
         cyc++;
      end
      total++;
      if (!seen || nout != 8) begin
         bad++;
         $display("FAIL raster_count: got %0d outputs required 8", nout);
      end
      total++;
      if (first_out - first_in != 3) begin
         bad++;
         $display("FAIL raster_latency: got %0d required 3", first_out - first_in);
      end
      total++;
      if (last_out - first_out != 7) begin
         bad++;
         $display("FAIL raster_throughput: got %0d required 7", last_out - first_out);
      end
      total++;
      if (first_obs !== {1'b0, 32'h1000} || last_obs !== {1'b1, 32'h101C}) begin
         bad++;
         $display("FAIL raster_ends: got %h/%h required %h/%h", first_obs, last_obs,
                  {1'b0, 32'h1000}, {1'b1, 32'h101C});
      end
      @(negedge clk);
      #1;
      total++;
      if ({done, busy} !== 2'b10 || addr_count !== 32'd8) begin
         bad++;
         $display("FAIL raster_done: got done=%b busy=%b count=%0d required 1 0 8",
                  done, busy, addr_count);
      end
      end_pass();
      #1;
      total++;
      if ({done, busy, in_ready} !== 3'b000) begin
         bad++;
         $display("FAIL raster_idle: got %b required 000", {done, busy, in_ready});
      end
      exp_q.delete();
   endtask

   task automatic test_wrap();
      int cyc = 0;
      logic ihs, ohs, seen, sent;
      logic [AW:0] obs, e;
      W = 15; H = 15; base_addr = 32'hFFFF_FFF0; row_stride = 4; elem_shift = 2'd2;
      start_pass();
      seen = 1'b0;
      sent = 1'b0;
      while (!seen && cyc < 20) begin
         step_cycle(!sent, 16'd8, 16'd0, 1'b1, 1'b1, ihs, ohs, obs);
         if (ihs) begin
            exp_q.push_back({1'b1, model_addr(16'd8, 16'd0)});
            sent = 1'b1;
         end
         if (ohs) begin
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            if (obs !== e || obs !== {1'b1, 32'h0000_0010}) begin
               bad++;
               $display("FAIL wrap_addr: got %h required %h", obs, {1'b1, 32'h0000_0010});
            end
            seen = 1'b1;
         end
         cyc++;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL wrap_timeout: got no output required one address");
      end
      @(negedge clk);
      #1;
      total++;
      if (done !== 1'b1 || addr_count !== 32'd1) begin
         bad++;
         $display("FAIL wrap_done: got done=%b count=%0d required 1 1", done, addr_count);
      end
`ifdef SFC_ADDR_BOUNDS_CHECK_EN
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL wrap_err: got %b required 0", err);
      end
`endif
      end_pass();
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int idx = 0, nout = 0, cyc = 0;
      logic ihs, ohs, seen;
      logic [AW:0] obs, e;
      logic [DW-1:0] cx, cy;
      W = 15; H = 15; base_addr = 32'h2000; row_stride = 16; elem_shift = 2'd1;
      start_pass();
      for (int i = 0; i < 10; i++) begin
         cx = DW'(idx + 1);
         cy = DW'(idx);
         step_cycle(idx < 6, cx, cy, idx == 5, 1'b0, ihs, ohs, obs);
         if (ihs) begin
            exp_q.push_back({idx == 5, model_addr(cx, cy)});
            idx++;
         end
      end
      #1;
      total++;
      if (idx != 4) begin
         bad++;
         $display("FAIL bp_accepted: got %0d required 4", idx);
      end
      total++;
      if ({in_ready, out_valid} !== 2'b01) begin
         bad++;
         $display("FAIL bp_stall: got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
      end
      seen = 1'b0;
      while (!seen && cyc < 60) begin
         cx = DW'(idx + 1);
         cy = DW'(idx);
         step_cycle(idx < 6, cx, cy, idx == 5, 1'b1, ihs, ohs, obs);
         if (ihs) begin
            exp_q.push_back({idx == 5, model_addr(cx, cy)});
            idx++;
         end
         if (ohs) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL bp_extra: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  bad++;
                  $display("FAIL bp_addr: got %h required %h", obs, e);
               end
            end
            nout++;
            if (obs[AW]) seen = 1'b1;
         end
         cyc++;
      end
      total++;
      if (nout != 6 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL bp_count: got %0d outputs, %0d pending required 6, 0", nout, exp_q.size());
      end
      end_pass();
      exp_q.delete();
   endtask

`ifdef SFC_ADDR_BOUNDS_CHECK_EN
   task automatic test_bounds();
      int idx = 0, nout = 0, cyc = 0;
      logic ihs, ohs, seen;
      logic [AW:0] obs, e;
      logic [DW-1:0] cx;
      W = 3; H = 1; base_addr = 32'h1000; row_stride = 4; elem_shift = 2'd2;
      start_pass();
      seen = 1'b0;
      while (!seen && cyc < 30) begin
         cx = (idx == 0) ? 16'd5 : 16'd1;
         step_cycle(idx < 2, cx, 16'd0, idx == 1, 1'b1, ihs, ohs, obs);
         if (ihs) begin
            if (cx <= W) exp_q.push_back({idx == 1, model_addr(cx, 16'd0)});
            idx++;
         end
         if (ohs) begin
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            if (obs !== e || obs !== {1'b1, 32'h1004}) begin
               bad++;
               $display("FAIL bounds_addr: got %h required %h", obs, {1'b1, 32'h1004});
            end
            nout++;
            if (obs[AW]) seen = 1'b1;
         end
         cyc++;
      end
      @(negedge clk);
      #1;
      total++;
      if (nout != 1 || err !== 1'b1 || addr_count !== 32'd1) begin
         bad++;
         $display("FAIL bounds_drop: got outs=%0d err=%b count=%0d required 1 1 1",
                  nout, err, addr_count);
      end
      end_pass();
      start_pass();
      #1;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL bounds_err_clear: got %b required 0", err);
      end
      end_pass();
      exp_q.delete();
   endtask
`endif

   task automatic test_reset_mid_pass();
      int idx = 0, nout = 0, cyc = 0;
      logic ihs, ohs;
      logic [AW:0] obs, e;
      logic [DW-1:0] cx, cy;
      W = 3; H = 1; base_addr = 32'h1000; row_stride = 4; elem_shift = 2'd2;
      start_pass();
      while (nout < 2 && cyc < 40) begin
         cx = DW'(idx % 4);
         cy = DW'(idx / 4);
         step_cycle(idx < 8, cx, cy, idx == 7, 1'b1, ihs, ohs, obs);
         if (ihs) begin
            exp_q.push_back({idx == 7, model_addr(cx, cy)});
            idx++;
         end
         if (ohs) begin
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            if (obs !== e) begin
               bad++;
               $display("FAIL rstmid_addr: got %h required %h", obs, e);
            end
            nout++;
         end
         cyc++;
      end
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_addr !== 32'h1008) begin
         bad++;
         $display("FAIL rstmid_third: got valid=%b addr=%h required 1 1008", out_valid, out_addr);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({out_valid, out_last, in_ready, busy, done} !== 5'b0 || addr_count !== '0) begin
         bad++;
         $display("FAIL rstmid_clear: got flags=%b count=%0d required 00000 0",
                  {out_valid, out_last, in_ready, busy, done}, addr_count);
      end
      in_valid = 1'b0;
      enable   = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({busy, done, out_valid} !== 3'b000) begin
         bad++;
         $display("FAIL rstmid_idle: got %b required 000", {busy, done, out_valid});
      end
   endtask

   initial begin
      enable     = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_x       = '0;
      in_y       = '0;
      out_ready  = 1'b0;
      W          = '0;
      H          = '0;
      base_addr  = '0;
      row_stride = '0;
      elem_shift = 2'd0;
      test_reset();
      test_idle_hold();
      test_raster();
      test_wrap();
      test_backpressure();
`ifdef SFC_ADDR_BOUNDS_CHECK_EN
      test_bounds();
`endif
      test_reset_mid_pass();
      test_raster();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sfc_addr_gen.md
# sfc_addr_gen

Downstream consumer of the raster/space-filling-curve coordinate generator. Accepts the (x, y) coordinate stream and converts each coordinate to a byte address: base_addr + ((y × row_stride + x) << elem_shift). It runs a two-stage arithmetic pipeline and a two-entry output skid buffer with valid/ready handshakes, so it feeds the memory-request stage at one address per cycle.

## Interface
- DATA_WIDTH, 15: coordinate/dimension width is DATA_WIDTH+1 bits.
- ADDR_WIDTH, 31: address width is ADDR_WIDTH+1 bits.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  starts a pass from IDLE; deasserting it in DONE returns the block to IDLE.
- W, H  in  DATA_WIDTH+1  max legal x / y, inclusive.
- base_addr  in  ADDR_WIDTH+1  byte address of (0,0).
- row_stride  in  DATA_WIDTH+1  elements per row.
- elem_shift  in  2  log2 of element bytes (1/2/4/8).
- in_x, in_y  in  DATA_WIDTH+1  coordinate.
- in_valid, in_last  in  1  coordinate valid; in_last marks the final coordinate of the pass.
- in_ready  out  1  coordinate accepted when in_valid && in_ready.
- out_addr  out  ADDR_WIDTH+1  computed address.
- out_valid, out_last  out  1  address valid; out_last marks the final address.
- out_ready  in  1  downstream accept.
- addr_count  out  ADDR_WIDTH+1  addresses issued this pass.
- busy, done  out  1  pass in progress / pass complete.
- err  out  1  sticky bounds error. Present only with SFC_ADDR_BOUNDS_CHECK_EN.

## Operation
- Reset values: in_ready=0, out_valid=0, out_last=0, out_addr=0, addr_count=0, busy=0, done=0, err=0, state=IDLE.
- FSM states and transitions:
  - IDLE → RUN when enable=1. On entry to RUN, addr_count and err clear.
  - RUN → DRAIN on the handshake of a coordinate with in_last=1.
  - DRAIN → DONE on the out handshake with out_last=1.
  - DONE → IDLE when enable=0.
- in_ready=1 only in RUN, and only when the pipeline can advance. busy=1 in RUN and DRAIN. done=1 only in DONE.
- Stage 1 registers lin = in_y × row_stride + in_x. The product is 2×(DATA_WIDTH+1) bits; the sum is truncated to ADDR_WIDTH+1 bits.
- Stage 2 registers out_addr = base_addr + (lin << elem_shift), modulo 2^(ADDR_WIDTH+1). No saturation.
- last propagates alongside data through every stage.
- Each stage advances when the next slot is empty or is draining in the same cycle. There are no bubbles at full throughput.
- The skid buffer holds 2 entries. in_ready depends only on registered state and has no combinational path from out_ready.
- addr_count increments on each out handshake and wraps at 2^(ADDR_WIDTH+1).
- base_addr, row_stride, elem_shift, W and H must be stable from IDLE exit to DONE. Changes during a pass give undefined addresses.
- An in_valid=1 coordinate outside RUN is not accepted and is held off by in_ready=0.
- Reset mid-pass: all valids clear immediately (asynchronously), pending addresses are discarded, and the block returns to IDLE.

## Timing
- Latency is 2 cycles: a coordinate accepted at edge N gives out_valid=1 after edge N+2 when the path is unstalled.
- Throughput is 1 address per cycle while in_valid and out_ready are held high.
- With out_ready=0, up to 4 coordinates are buffered (2 stage registers + 2 skid entries). in_ready falls on the cycle after the 4th is accepted.
- done rises the cycle after the out_last handshake.

## Configuration
- SFC_ADDR_BOUNDS_CHECK_EN defined:
  - In stage 1, a coordinate with x>W or y>H is accepted but dropped: no address is produced and err sets (sticky until the next pass).
  - If the dropped coordinate carries in_last, out_last is attached to a zero-length marker. The FSM still reaches DONE, with no extra address counted.
- Not defined: no check is made, every accepted coordinate produces an address, and the err port is absent.

## Structure
- Shared package sfc_pkg holds:
  - FSM state encoding for IDLE, RUN, DRAIN, DONE.
  - Default DATA_WIDTH/ADDR_WIDTH constants.
  - elem_shift encoding constants.
- Sub-module sfc_skid_buf is a 2-entry valid/ready skid buffer parameterised by payload width (address + last).

## Test plan
- Raster: W=3, H=1, base=0x1000, stride=4, shift=2, coordinates (0,0)…(3,1) with last on (3,1) → addresses 0x1000, 0x1004, 0x1008, 0x100C, 0x1010…0x101C; out_last on 0x101C; addr_count=8; done one cycle later.
- Wrap: base=0xFFFFFFF0, (x=8, y=0), shift=2 → out_addr=0x00000010, no error.
- Backpressure: out_ready held 0 for 10 cycles with in_valid=1 → exactly 4 accepted, in_ready=0; on release all addresses emerge in order with no loss or duplication.
- Bounds (macro defined): W=3, coordinate (5,0) → no output, err=1; following (1,0) → 0x1004.
- Reset: assert rst low during the 3rd address of the raster pass → out_valid=0 immediately, state IDLE, addr_count=0; the next pass is clean.
- Handshake idle: in_valid=1 while in IDLE → in_ready=0 and no address until enable=1.
